// File: rtl/hwpe_stream_source_sequencer_if.sv
// Handshake bundles for the source sequencer: descriptor push side and streamer-source side.
// The "master" modport drives the request/payload; the "slave" modport answers it.
interface hwpe_seq_desc_if #(
  parameter int unsigned REPEAT_WIDTH = 8
);
  logic                    valid;
  logic                    ready;
  logic [31:0]             addr;
  logic [15:0]             trans_size;
  logic [15:0]             line_stride;
  logic [15:0]             line_length;
  logic [REPEAT_WIDTH-1:0] rep;
  logic [31:0]             jump;

  modport master (
    output valid, addr, trans_size, line_stride, line_length, rep, jump,
    input  ready
  );
  modport slave (
    input  valid, addr, trans_size, line_stride, line_length, rep, jump,
    output ready
  );
endinterface

interface hwpe_seq_src_if;
  logic        req_start;
  logic        ready_start;
  logic        done;
  logic [31:0] addr;
  logic [15:0] trans_size;
  logic [15:0] line_stride;
  logic [15:0] line_length;

  modport master (
    output req_start, addr, trans_size, line_stride, line_length,
    input  ready_start, done
  );
  modport slave (
    input  req_start, addr, trans_size, line_stride, line_length,
    output ready_start, done
  );
endinterface

// File: rtl/hwpe_stream_source_sequencer.sv
// Queues source-transfer descriptors and replays each one on the streamer source,
// optionally repeated with an address jump, counting completed jobs.
//
// state | meaning
// IDLE  | waiting for a descriptor; pops and loads the FIFO head
// SKIP  | zero-size descriptor: job_done_o shown, source untouched
// START | src_req_start_o high until the source accepts
// WAIT  | transfer running; waiting for src_done_i
module hwpe_stream_source_sequencer #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  hwpe_seq_desc_if.slave              desc,
  hwpe_seq_src_if.master              src,
  output logic                        busy_o,
  output logic                        job_done_o,
  output logic                        all_done_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic [15:0]                 jobs_completed_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SKIP, START, WAIT} state_e;

  typedef struct packed {
    logic [31:0]             addr;
    logic [15:0]             trans_size;
    logic [15:0]             line_stride;
    logic [15:0]             line_length;
    logic [REPEAT_WIDTH-1:0] rep;
    logic [31:0]             jump;
  } desc_t;

  state_e                  state_q, state_d;
  desc_t                   mem_q [FIFO_DEPTH];
  desc_t                   desc_in, head;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    push, pop;

  logic [31:0]             addr_q, addr_d, jump_q, jump_d;
  logic [15:0]             size_q, size_d, stride_q, stride_d, length_q, length_d;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d, rep_cnt_q, rep_cnt_d;
  logic                    job_done_q, job_done_d, all_done_q, all_done_d;
  logic [15:0]             jobs_q, jobs_d;

  assign desc_in.addr        = desc.addr;
  assign desc_in.trans_size  = desc.trans_size;
  assign desc_in.line_stride = desc.line_stride;
  assign desc_in.line_length = desc.line_length;
  assign desc_in.rep         = desc.rep;
  assign desc_in.jump        = desc.jump;

  assign desc.ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = desc.valid & desc.ready & ~clear_i;
  assign head       = mem_q[rd_ptr_q];
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  // Payload storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      jump_q     <= '0;
      size_q     <= '0;
      stride_q   <= '0;
      length_q   <= '0;
      rep_q      <= '0;
      rep_cnt_q  <= '0;
      job_done_q <= 1'b0;
      all_done_q <= 1'b0;
      jobs_q     <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      jump_q     <= '0;
      size_q     <= '0;
      stride_q   <= '0;
      length_q   <= '0;
      rep_q      <= '0;
      rep_cnt_q  <= '0;
      job_done_q <= 1'b0;
      all_done_q <= 1'b0;
      jobs_q     <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      addr_q     <= addr_d;
      jump_q     <= jump_d;
      size_q     <= size_d;
      stride_q   <= stride_d;
      length_q   <= length_d;
      rep_q      <= rep_d;
      rep_cnt_q  <= rep_cnt_d;
      job_done_q <= job_done_d;
      all_done_q <= all_done_d;
      jobs_q     <= jobs_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    addr_d     = addr_q;
    jump_d     = jump_q;
    size_d     = size_q;
    stride_d   = stride_q;
    length_d   = length_q;
    rep_d      = rep_q;
    rep_cnt_d  = rep_cnt_q;
    job_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          addr_d    = head.addr;
          jump_d    = head.jump;
          size_d    = head.trans_size;
          stride_d  = head.line_stride;
          length_d  = head.line_length;
          rep_d     = head.rep;
          rep_cnt_d = '0;
          // Zero-size jobs complete immediately; the pulse shows while in SKIP.
          if (head.trans_size == '0) begin
            state_d    = SKIP;
            job_done_d = 1'b1;
          end else begin
            state_d = START;
          end
        end
      end
      SKIP:  state_d = IDLE;
      START: if (src.ready_start) state_d = WAIT;
      WAIT: begin
        if (src.done) begin
          if (rep_cnt_q == rep_q) begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            rep_cnt_d = rep_cnt_q + REPEAT_WIDTH'(1);
            addr_d    = addr_q + jump_q;
            state_d   = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign all_done_d = job_done_d & (count_d == '0);
  assign jobs_d     = jobs_q + 16'(job_done_d);

  assign src.req_start   = (state_q == START);
  assign src.addr        = addr_q;
  assign src.trans_size  = size_q;
  assign src.line_stride = stride_q;
  assign src.line_length = length_q;

  assign busy_o           = (state_q != IDLE) | (count_q != '0);
  assign job_done_o       = job_done_q;
  assign all_done_o       = all_done_q;
  assign fifo_count_o     = count_q;
  assign jobs_completed_o = jobs_q;

endmodule
